// File: rtl/imem_resp_if.sv
// Fetch and loader signals of the instruction memory responder.
// The master side is the fetch/load agent; the slave side is imem_resp.
interface imem_resp_if;
  logic [31:0] pc_i;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        fault_o;
  logic        ld_start_i;
  logic        ld_valid_i;
  logic        ld_ready_o;
  logic [31:0] ld_addr_i;
  logic [31:0] ld_data_i;
  logic        ld_done_i;
  logic [15:0] ld_cnt_o;
  logic        ld_err_o;

  modport master (
    output pc_i, ld_start_i, ld_valid_i, ld_addr_i, ld_data_i, ld_done_i,
    input  instr_o, instr_valid_o, fault_o, ld_ready_o, ld_cnt_o, ld_err_o
  );

  modport slave (
    input  pc_i, ld_start_i, ld_valid_i, ld_addr_i, ld_data_i, ld_done_i,
    output instr_o, instr_valid_o, fault_o, ld_ready_o, ld_cnt_o, ld_err_o
  );
endinterface

// File: rtl/imem_resp.sv
// Instruction memory with a load mode (word writes from a loader) and a run mode
// (one fetch per cycle, 1-cycle latency, NOP plus fault on bad addresses).
module imem_resp #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic        clk,
  input logic        rst,
  imem_resp_if.slave bus
);

  localparam int unsigned IdxW      = $clog2(DEPTH);
  localparam logic [31:0] AddrLimit = 32'(4 * DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;
  // Which source drives instr_o; held across non-RUN cycles.
  typedef enum logic [1:0] {SelZero, SelMem, SelNop} sel_e;

  state_e      state_q, state_d;
  sel_e        sel_q, sel_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;

  logic            ld_hs, ld_ok;
  logic            fetch, fetch_ok;
  logic            mem_we, mem_re;
  logic [IdxW-1:0] mem_idx;
  logic [31:0]     mem [DEPTH];
  logic [31:0]     mem_rdata_q;

  assign ld_ok    = (bus.ld_addr_i[1:0] == 2'b00) && (bus.ld_addr_i < AddrLimit);
  assign fetch_ok = (bus.pc_i[1:0] == 2'b00) && (bus.pc_i < AddrLimit);
  assign ld_hs    = (state_q == StLoad) && bus.ld_valid_i;
  assign fetch    = (state_q == StRun);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = bus.ld_start_i ? StLoad : StRun;
      StLoad:  if (bus.ld_done_i) state_d = StRun;
      StRun:   if (bus.ld_start_i) state_d = StLoad;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if ((state_q != StLoad) && (state_d == StLoad)) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if (ld_hs) begin
      if (!ld_ok) begin
        err_d = 1'b1;
      end else if (cnt_q != 16'hFFFF) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    valid_d = fetch;
    fault_d = fetch && !fetch_ok;
    sel_d   = sel_q;
    if (fetch) sel_d = fetch_ok ? SelMem : SelNop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= SelZero;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  // Single shared port: writes only in LOAD, reads only in RUN.
  assign mem_we  = ld_hs && ld_ok && !rst;
  assign mem_re  = fetch && fetch_ok && !rst;
  assign mem_idx = (state_q == StLoad) ? bus.ld_addr_i[IdxW+1:2] : bus.pc_i[IdxW+1:2];

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= bus.ld_data_i;
    if (mem_re) mem_rdata_q <= mem[mem_idx];
  end

  always_comb begin
    unique case (sel_q)
      SelMem:  bus.instr_o = mem_rdata_q;
      SelNop:  bus.instr_o = NOP_INSTR;
      default: bus.instr_o = 32'h0;
    endcase
  end

  assign bus.instr_valid_o = valid_q;
  assign bus.fault_o       = fault_q;
  assign bus.ld_ready_o    = (state_q == StLoad);
  assign bus.ld_cnt_o      = cnt_q;
  assign bus.ld_err_o      = err_q;

endmodule

// File: tb/tb_imem_resp.sv
// Randomized scoreboard bench for imem_resp: a mode-level reference model queues
// expected fetch results; a negedge monitor pops and compares on instr_valid_o.
module tb_imem_resp;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_resp_if bus ();

  imem_resp #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  typedef enum int {MIdle, MLoad, MRun} mode_t;

  exp_t         exp_q[$];
  logic [31:0]  ref_mem[int];
  logic [31:0]  wr_addrs[$];
  mode_t        mode = MIdle;
  int unsigned  m_cnt = 0;
  bit           m_err = 0;
  logic [31:0]  m_last = 32'h0;
  bit           m_valid = 0;
  int unsigned  n_vec = 0;
  int unsigned  n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < LIMIT);
  endfunction

  // Apply the current inputs for one clock edge, advancing the reference model first.
  task automatic step();
    exp_t e;
    m_valid = 0;
    if (rst) begin
      mode = MIdle; m_cnt = 0; m_err = 0; m_last = 32'h0;
    end else begin
      case (mode)
        MIdle: begin
          if (bus.ld_start_i) begin mode = MLoad; m_cnt = 0; m_err = 0; end
          else mode = MRun;
        end
        MRun: begin
          e.fault = !addr_ok(bus.pc_i);
          e.instr = e.fault ? NOP : ref_mem[int'(bus.pc_i >> 2)];
          exp_q.push_back(e);
          m_last  = e.instr;
          m_valid = 1;
          if (bus.ld_start_i) begin mode = MLoad; m_cnt = 0; m_err = 0; end
        end
        default: begin
          if (bus.ld_valid_i) begin
            if (addr_ok(bus.ld_addr_i)) begin
              if (!ref_mem.exists(int'(bus.ld_addr_i >> 2))) wr_addrs.push_back(bus.ld_addr_i);
              ref_mem[int'(bus.ld_addr_i >> 2)] = bus.ld_data_i;
              if (m_cnt < 65535) m_cnt++;
            end else begin
              m_err = 1;
            end
          end
          if (bus.ld_done_i) mode = MRun;
        end
      endcase
    end
    @(posedge clk);
    #1;
    chk("ld_ready", 32'(bus.ld_ready_o), 32'(mode == MLoad));
    chk("ld_cnt", 32'(bus.ld_cnt_o), m_cnt);
    chk("ld_err", 32'(bus.ld_err_o), 32'(m_err));
    chk("instr_valid", 32'(bus.instr_valid_o), 32'(m_valid));
    if (!m_valid) begin
      chk("instr_hold", bus.instr_o, m_last);
      chk("fault_idle", 32'(bus.fault_o), 32'h0);
    end
  endtask

  task automatic clear_inputs();
    bus.ld_start_i = 1'b0;
    bus.ld_valid_i = 1'b0;
    bus.ld_done_i  = 1'b0;
  endtask

  task automatic ld_write(input logic [31:0] a, input logic [31:0] d, input bit done);
    clear_inputs();
    bus.ld_valid_i = 1'b1;
    bus.ld_addr_i  = a;
    bus.ld_data_i  = d;
    bus.ld_done_i  = done;
    step();
    clear_inputs();
  endtask

  task automatic fetch(input logic [31:0] pc);
    clear_inputs();
    bus.pc_i = pc;
    step();
  endtask

  task automatic enter_load();
    clear_inputs();
    bus.ld_start_i = 1'b1;
    step();
    clear_inputs();
  endtask

  task automatic finish_load();
    clear_inputs();
    bus.ld_done_i = 1'b1;
    step();
    clear_inputs();
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] a;
    case ($urandom_range(0, 3))
      0, 1: a = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
      2:    a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      default: a = $urandom_range(0, 1) == 1 ? LIMIT + (32'($urandom_range(0, 15)) << 2)
                                             : ($urandom() | 32'h8000_0000) & 32'hFFFF_FFFC;
    endcase
    return a;
  endfunction

  // Monitor: every valid DUT result must match the oldest outstanding expectation.
  exp_t mon_e;
  always @(negedge clk) begin
    if (bus.instr_valid_o) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got instr %h with nothing expected at %0t",
                 bus.instr_o, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("instr", bus.instr_o, mon_e.instr);
        chk("fault", 32'(bus.fault_o), 32'(mon_e.fault));
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.pc_i = 32'h0;
    bus.ld_addr_i = 32'h0;
    bus.ld_data_i = 32'h0;
    clear_inputs();
    step();
    step();
    chk("rst_instr", bus.instr_o, 32'h0);

    // Initial load of two words, then fetches.
    rst = 1'b0;
    enter_load();
    ld_write(32'h0, 32'h0050_0093, 0);
    ld_write(32'h4, 32'h0010_8113, 0);
    finish_load();
    chk("ld_cnt_two", 32'(bus.ld_cnt_o), 32'd2);
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h2);
    fetch(LIMIT);
    fetch(LIMIT + 32'h4);

    // Last RUN fetch before LOAD is still delivered; bad writes set ld_err.
    bus.pc_i = 32'h4;
    enter_load();
    ld_write(32'h6, 32'h1111_1111, 0);
    ld_write(LIMIT, 32'h2222_2222, 0);
    finish_load();
    fetch(32'h4);
    enter_load();
    chk("err_cleared", 32'(bus.ld_err_o), 32'h0);
    ld_write(32'h8, 32'hDEAD_BEEF, 1);
    fetch(32'h8);
    fetch(32'h0);

    // Randomized load/fetch rounds.
    for (int r = 0; r < 12; r++) begin
      enter_load();
      for (int i = 0; i < 20; i++) begin
        logic [31:0] a;
        if ($urandom_range(0, 3) != 0) a = 32'($urandom_range(0, DEPTH - 1)) << 2;
        else a = ($urandom_range(0, 1) == 1) ? (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'h1
                                             : LIMIT + (32'($urandom()) & 32'h0FFF_FFFC);
        if ($urandom_range(0, 4) == 0) begin
          clear_inputs();
          bus.ld_addr_i = a;
          step();
        end else begin
          ld_write(a, $urandom(), (i == 19) && ($urandom_range(0, 1) == 1));
        end
      end
      if (mode == MLoad) finish_load();
      for (int i = 0; i < 40; i++) fetch(rand_pc());
      if (r == 6) begin
        rst = 1'b1;
        fetch(rand_pc());
        rst = 1'b0;
        fetch(rand_pc());
        fetch(rand_pc());
      end
    end

    // Reset in the middle of LOAD keeps memory contents.
    enter_load();
    ld_write(32'h10, 32'hA5A5_0001, 0);
    ld_write(32'h14, 32'hA5A5_0002, 0);
    ld_write(32'h18, 32'hA5A5_0003, 0);
    bus.ld_valid_i = 1'b1;
    bus.ld_addr_i  = 32'h1C;
    bus.ld_data_i  = 32'hBAD0_BAD0;
    rst = 1'b1;
    step();
    chk("rst_load_instr", bus.instr_o, 32'h0);
    chk("rst_load_cnt", 32'(bus.ld_cnt_o), 32'h0);
    rst = 1'b0;
    clear_inputs();
    step();
    fetch(32'h10);
    fetch(32'h14);
    fetch(32'h18);
    fetch(32'h0);

    clear_inputs();
    bus.ld_start_i = 1'b1;
    step();
    clear_inputs();
    step();
    step();
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
